// File: rtl/ysyx_22050550_score_board_if.sv
// Issue/commit signal bundle between the IDU/WBU side of the pipe and the
// register-busy scoreboard.
interface ysyx_22050550_score_board_if;
  logic       io_IDU_valid;
  logic [4:0] io_IDU_raddr1;
  logic       io_IDU_ren1;
  logic [4:0] io_IDU_raddr2;
  logic       io_IDU_ren2;
  logic [4:0] io_IDU_waddr;
  logic       io_IDU_wen;
  logic       io_IDU_fire;
  logic       io_IDU_stall;
  logic       io_WBU_valid;
  logic [4:0] io_WBU_waddr;
  logic       io_WBU_wen;
  logic       io_flush;
  logic       io_busy_any;

  modport master (
    output io_IDU_valid, io_IDU_raddr1, io_IDU_ren1, io_IDU_raddr2, io_IDU_ren2,
    output io_IDU_waddr, io_IDU_wen, io_IDU_fire,
    output io_WBU_valid, io_WBU_waddr, io_WBU_wen, io_flush,
    input  io_IDU_stall, io_busy_any
  );

  modport slave (
    input  io_IDU_valid, io_IDU_raddr1, io_IDU_ren1, io_IDU_raddr2, io_IDU_ren2,
    input  io_IDU_waddr, io_IDU_wen, io_IDU_fire,
    input  io_WBU_valid, io_WBU_waddr, io_WBU_wen, io_flush,
    output io_IDU_stall, io_busy_any
  );
endinterface

// File: rtl/ysyx_22050550_score_board.sv
// Register-busy scoreboard: one in-flight writer counter per GPR, stalls the
// IDU on RAW hazards the WBU bypass cannot cover and on counter-full WAW.
module ysyx_22050550_score_board #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_22050550_score_board_if.slave    sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [1:NREG-1];
  logic [CNT_W-1:0] cnt_d [1:NREG-1];
  logic [CNT_W-1:0] cnt_v [NREG];
  logic [NREG-1:0]  dec;
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  busy;
  logic             rd1_haz;
  logic             rd2_haz;
  logic             waw_full;
  logic             stall;
  logic             issue_wr;
  logic             busy_any;

  // Counters read as zero while reset is held so outputs are defined from the
  // very first reset cycle.
  always_comb begin
    cnt_v[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_v[r] = reset ? '0 : cnt_q[r];
    end
  end

  always_comb begin
    dec  = '0;
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      dec[r]  = sb.io_WBU_valid & sb.io_WBU_wen &
                (sb.io_WBU_waddr == 5'(r)) & (cnt_v[r] != '0);
      // A lone pending writer committing now is forwarded by the bypass.
      busy[r] = (cnt_v[r] > CNT_ONE) | ((cnt_v[r] == CNT_ONE) & ~dec[r]);
    end
  end

  always_comb begin
    rd1_haz  = sb.io_IDU_ren1 & (sb.io_IDU_raddr1 != 5'd0) & busy[sb.io_IDU_raddr1];
    rd2_haz  = sb.io_IDU_ren2 & (sb.io_IDU_raddr2 != 5'd0) & busy[sb.io_IDU_raddr2];
    waw_full = sb.io_IDU_wen & (sb.io_IDU_waddr != 5'd0) &
               (cnt_v[sb.io_IDU_waddr] == CNT_MAX) & ~dec[sb.io_IDU_waddr];
    stall    = sb.io_IDU_valid & (rd1_haz | rd2_haz | waw_full);
    issue_wr = sb.io_IDU_valid & sb.io_IDU_fire & ~stall & sb.io_IDU_wen;
  end

  always_comb begin
    inc = '0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = issue_wr & (sb.io_IDU_waddr == 5'(r));
    end
  end

  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (sb.io_flush) begin
        cnt_d[r] = '0;
      end else if (inc[r] & ~dec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec[r] & ~inc[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int r = 1; r < NREG; r++) begin
      if (reset) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      busy_any = busy_any | (cnt_v[r] != '0);
    end
  end

  assign sb.io_IDU_stall = stall;
  assign sb.io_busy_any  = busy_any;

endmodule

// File: tb/tb_ysyx_22050550_score_board.sv
// Directed-vector bench for the register-busy scoreboard; per-cycle expected
// stall/busy_any values are queued by the driver and checked by a monitor.
module tb_ysyx_22050550_score_board;

  logic clock;
  logic reset;

  ysyx_22050550_score_board_if sbif ();

  ysyx_22050550_score_board #(.NREG(32), .CNT_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sbif)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    string nm;
    bit    stall;
    bit    busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: outputs are sampled at the negedge in the middle of each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (sbif.io_IDU_stall === e.stall) n_pass++;
        else $display("FAIL %s stall: got %b expected %b", e.nm, sbif.io_IDU_stall, e.stall);
        n_checks++;
        if (sbif.io_busy_any === e.busy) n_pass++;
        else $display("FAIL %s busy_any: got %b expected %b", e.nm, sbif.io_busy_any, e.busy);
      end
    end
  end

  // One cycle of stimulus: IDU fields, WBU fields, flush/reset, expectations.
  task automatic cyc(input string nm,
                     input bit v, input bit re1, input logic [4:0] r1,
                     input bit re2, input logic [4:0] r2,
                     input bit we, input logic [4:0] wa, input bit fire,
                     input bit wv, input logic [4:0] ww,
                     input bit fl, input bit rs,
                     input bit es, input bit eb);
    exp_t e;
    sbif.io_IDU_valid  = v;
    sbif.io_IDU_ren1   = re1;
    sbif.io_IDU_raddr1 = r1;
    sbif.io_IDU_ren2   = re2;
    sbif.io_IDU_raddr2 = r2;
    sbif.io_IDU_wen    = we;
    sbif.io_IDU_waddr  = wa;
    sbif.io_IDU_fire   = fire;
    sbif.io_WBU_valid  = wv;
    sbif.io_WBU_wen    = wv;
    sbif.io_WBU_waddr  = ww;
    sbif.io_flush      = fl;
    reset              = rs;
    e.nm = nm; e.stall = es; e.busy = eb;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string nm, input bit eb);
    cyc(nm, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, eb);
  endtask

  task automatic fire_w(input string nm, input logic [4:0] wa, input bit eb);
    cyc(nm, 1, 0, 5'd0, 0, 5'd0, 1, wa, 1, 0, 5'd0, 0, 0, 0, eb);
  endtask

  task automatic commit(input string nm, input logic [4:0] ww, input bit eb);
    cyc(nm, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, ww, 0, 0, 0, eb);
  endtask

  initial begin
    int wait_cyc;
    // Reset: counters read as zero, read of x5 does not stall.
    cyc("rst_read", 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
    cyc("rst_idle", 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
    idle("post_rst", 0);

    // RAW on x5, resolved by bypass in the commit cycle.
    fire_w("x5_fire", 5'd5, 0);
    cyc("x5_raw1", 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    cyc("x5_raw2", 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 0, 0, 1, 1);
    cyc("x5_bypass", 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 0, 0, 1);
    cyc("x5_clear", 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);

    // Read-modify-write of the same register with an idle counter.
    cyc("addi_x5", 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, 1, 0, 5'd0, 0, 0, 0, 0);
    cyc("addi_cnt1", 1, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    commit("addi_commit", 5'd5, 1);
    idle("addi_drained", 0);

    // Counter-full WAW guard on x7.
    fire_w("x7_f1", 5'd7, 0);
    fire_w("x7_f2", 5'd7, 1);
    fire_w("x7_f3", 5'd7, 1);
    cyc("x7_full", 1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 1, 0, 5'd0, 0, 0, 1, 1);
    cyc("x7_full_dec", 1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 1, 1, 5'd7, 0, 0, 0, 1);
    cyc("x7_still3", 1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 5'd0, 0, 0, 1, 1);
    commit("x7_c1", 5'd7, 1);
    commit("x7_c2", 5'd7, 1);
    cyc("x7_c3_not_full", 1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 1, 5'd7, 0, 0, 0, 1);
    commit("x7_underflow", 5'd7, 0);
    idle("x7_zero", 0);

    // cnt>1 stays busy even while one writer commits.
    fire_w("x9_f1", 5'd9, 0);
    fire_w("x9_f2", 5'd9, 1);
    cyc("x9_cnt2_dec", 1, 0, 5'd0, 1, 5'd9, 0, 5'd0, 0, 1, 5'd9, 0, 0, 1, 1);
    cyc("x9_cnt1", 1, 0, 5'd0, 1, 5'd9, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    cyc("x9_bypass", 1, 0, 5'd0, 1, 5'd9, 0, 5'd0, 0, 1, 5'd9, 0, 0, 0, 1);
    idle("x9_zero", 0);

    // x0 is never tracked.
    for (int i = 0; i < 4; i++)
      cyc("x0_mix", 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
    cyc("x0_commit", 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0);
    idle("x0_idle", 0);

    // Flush drops everything, including a same-cycle issue.
    fire_w("fl_x3a", 5'd3, 0);
    fire_w("fl_x3b", 5'd3, 1);
    fire_w("fl_x4", 5'd4, 1);
    cyc("fl_fire", 1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 1, 0, 5'd0, 1, 0, 0, 1);
    cyc("fl_after", 1, 1, 5'd3, 1, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    commit("fl_x3_commit", 5'd3, 0);
    idle("fl_no_under", 0);

    // Same setup, cleared by reset instead.
    fire_w("rs_x3a", 5'd3, 0);
    fire_w("rs_x3b", 5'd3, 1);
    fire_w("rs_x4", 5'd4, 1);
    cyc("rs_fire", 1, 1, 5'd3, 0, 5'd0, 1, 5'd3, 1, 0, 5'd0, 0, 1, 0, 0);
    cyc("rs_after", 1, 1, 5'd3, 1, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    commit("rs_x3_commit", 5'd3, 0);
    idle("rs_no_under", 0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clock);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
